// File: rtl/vga_pkg.sv
// Shared VGA timing constants and frame-buffer helpers for the camera path.
package vga_pkg;

  // 640x480@60 Hz default timing
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL      = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL      = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  // 320x240 frame buffer
  localparam int FB_WIDTH_DEF = 320;

  // RGB444 field positions, shared with the capture block
  localparam int RGB_R_HI = 11;
  localparam int RGB_R_LO = 8;
  localparam int RGB_G_HI = 7;
  localparam int RGB_G_LO = 4;
  localparam int RGB_B_HI = 3;
  localparam int RGB_B_LO = 0;

  // Frame-buffer address for a screen pixel with 2x2 replication. The row
  // multiply is unrolled into shifted adds over the set bits of the constant
  // width, so 320 becomes (row<<8)+(row<<6) with no multiplier.
  function automatic logic [16:0] fb_addr(input logic [9:0] h, input logic [9:0] v,
                                          input int width);
    logic [16:0] row;
    logic [16:0] acc;
    row = 17'(v >> 1);
    acc = 17'(h >> 1);
    for (int i = 0; i < 10; i++) begin
      if (width[i]) acc = acc + (row << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Stage-0 VGA raster counters with raw sync/active decode and frame markers.
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] o_h_count,
  output logic [9:0] o_v_count,
  output logic       o_active,
  output logic       o_hs_raw,
  output logic       o_vs_raw,
  output logic       o_frame_start,
  output logic       o_in_vblank
);

  localparam int LP_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int LP_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int LP_HS_START = H_VISIBLE + H_FRONT;
  localparam int LP_HS_END   = LP_HS_START + H_SYNC;
  localparam int LP_VS_START = V_VISIBLE + V_FRONT;
  localparam int LP_VS_END   = LP_VS_START + V_SYNC;

  logic [9:0] r_h_count;
  logic [9:0] r_v_count;
  logic       w_line_end;
  logic       w_frame_end;

  assign w_line_end  = (r_h_count == 10'(LP_H_TOTAL - 1));
  assign w_frame_end = w_line_end && (r_v_count == 10'(LP_V_TOTAL - 1));

  // Pixel and line counters, both wrap at the end of the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_line_end) begin
      r_h_count <= '0;
      r_v_count <= w_frame_end ? 10'd0 : r_v_count + 10'd1;
    end else begin
      r_h_count <= r_h_count + 10'd1;
    end
  end

  // Frame markers for software: not aligned to the pixel pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_frame_start <= 1'b0;
      o_in_vblank   <= 1'b0;
    end else begin
      o_frame_start <= w_frame_end;
      o_in_vblank   <= (r_v_count >= 10'(V_VISIBLE));
    end
  end

  assign o_h_count = r_h_count;
  assign o_v_count = r_v_count;
  assign o_active  = (r_h_count < 10'(H_VISIBLE)) && (r_v_count < 10'(V_VISIBLE));
  assign o_hs_raw  = !((r_h_count >= 10'(LP_HS_START)) && (r_h_count < 10'(LP_HS_END)));
  assign o_vs_raw  = !((r_v_count >= 10'(LP_VS_START)) && (r_v_count < 10'(LP_VS_END)));

endmodule

// File: rtl/vga_framebuffer_reader.sv
// VGA scan-out of the 320x240 camera frame buffer with 2x2 pixel replication.
module vga_framebuffer_reader import vga_pkg::*; #(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int FB_WIDTH   = FB_WIDTH_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [16:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start,
  output logic        in_vblank
);

  // One stage for the address register plus the BRAM read latency
  localparam int LP_DL = 1 + RD_LATENCY;

  logic [9:0]       w_h_count;
  logic [9:0]       w_v_count;
  logic             w_active;
  logic             w_hs_raw;
  logic             w_vs_raw;
  logic [LP_DL-1:0] r_act_dl;
  logic [LP_DL-1:0] r_hs_dl;
  logic [LP_DL-1:0] r_vs_dl;
  logic             w_act_aligned;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_h_count     (w_h_count),
    .o_v_count     (w_v_count),
    .o_active      (w_active),
    .o_hs_raw      (w_hs_raw),
    .o_vs_raw      (w_vs_raw),
    .o_frame_start (frame_start),
    .o_in_vblank   (in_vblank)
  );

  // Read address tracks the raster only while visible, so blanking never reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
    end else if (w_active) begin
      rd_addr <= fb_addr(w_h_count, w_v_count, FB_WIDTH);
    end
  end

  // Delay active/syncs so they line up with rd_data at the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_dl <= '0;
      r_hs_dl  <= '1;
      r_vs_dl  <= '1;
    end else begin
      r_act_dl <= {r_act_dl[LP_DL-2:0], w_active};
      r_hs_dl  <= {r_hs_dl[LP_DL-2:0], w_hs_raw};
      r_vs_dl  <= {r_vs_dl[LP_DL-2:0], w_vs_raw};
    end
  end

  assign w_act_aligned = r_act_dl[LP_DL-1];

  // DAC and sync pins all switch on the same edge; colour forced dark when blanked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_r  <= w_act_aligned ? rd_data[RGB_R_HI:RGB_R_LO] : 4'h0;
      vga_g  <= w_act_aligned ? rd_data[RGB_G_HI:RGB_G_LO] : 4'h0;
      vga_b  <= w_act_aligned ? rd_data[RGB_B_HI:RGB_B_LO] : 4'h0;
      vga_hs <= r_hs_dl[LP_DL-1];
      vga_vs <= r_vs_dl[LP_DL-1];
    end
  end

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Scoreboard bench: two full-size readers (read latency 1 and 2) and one
// reduced-geometry reader so whole frames fit in a short run.
module tb_vga_framebuffer_reader;

  localparam int ND = 3;
  localparam int T_HV  [ND] = '{640, 640, 16};
  localparam int T_HF  [ND] = '{16, 16, 4};
  localparam int T_HS  [ND] = '{96, 96, 6};
  localparam int T_HB  [ND] = '{48, 48, 4};
  localparam int T_VV  [ND] = '{480, 480, 8};
  localparam int T_VF  [ND] = '{10, 10, 2};
  localparam int T_VS  [ND] = '{2, 2, 2};
  localparam int T_VB  [ND] = '{33, 33, 3};
  localparam int T_FBW [ND] = '{320, 320, 8};
  localparam int T_LAT [ND] = '{1, 2, 1};

  logic        clk;
  logic        rst_n;
  logic        force_fff;
  logic [16:0] addr  [ND];
  logic [11:0] rdata [ND];
  logic [3:0]  pr    [ND];
  logic [3:0]  pg    [ND];
  logic [3:0]  pb    [ND];
  logic        hs    [ND];
  logic        vs    [ND];
  logic        fs    [ND];
  logic        vb    [ND];
  logic [13:0] pins  [ND];

  logic [11:0] m0, m1a, m1b, m2;

  int          n_tests;
  int          n_fail;
  int          mh [ND];
  int          mv [ND];
  logic [16:0] maddr [ND];
  logic [13:0] q0 [$];
  logic [13:0] q1 [$];
  logic [13:0] q2 [$];
  int          hs_run [ND];
  int          first_fall [ND];
  int          vs_run;
  int          last_fs;

  vga_framebuffer_reader #(.RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(addr[0]), .rd_data(rdata[0]),
    .vga_r(pr[0]), .vga_g(pg[0]), .vga_b(pb[0]), .vga_hs(hs[0]), .vga_vs(vs[0]),
    .frame_start(fs[0]), .in_vblank(vb[0]));

  vga_framebuffer_reader #(.RD_LATENCY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(addr[1]), .rd_data(rdata[1]),
    .vga_r(pr[1]), .vga_g(pg[1]), .vga_b(pb[1]), .vga_hs(hs[1]), .vga_vs(vs[1]),
    .frame_start(fs[1]), .in_vblank(vb[1]));

  vga_framebuffer_reader #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .FB_WIDTH(8), .RD_LATENCY(1)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rd_addr(addr[2]), .rd_data(rdata[2]),
    .vga_r(pr[2]), .vga_g(pg[2]), .vga_b(pb[2]), .vga_hs(hs[2]), .vga_vs(vs[2]),
    .frame_start(fs[2]), .in_vblank(vb[2]));

  always #20 clk = ~clk;

  // BRAM models returning addr[11:0] after the configured read latency
  always @(posedge clk) begin
    m0  <= addr[0][11:0];
    m1a <= addr[1][11:0];
    m1b <= m1a;
    m2  <= addr[2][11:0];
  end

  assign rdata[0] = force_fff ? 12'hFFF : m0;
  assign rdata[1] = force_fff ? 12'hFFF : m1b;
  assign rdata[2] = force_fff ? 12'hFFF : m2;

  assign pins[0] = {hs[0], vs[0], pr[0], pg[0], pb[0]};
  assign pins[1] = {hs[1], vs[1], pr[1], pg[1], pb[1]};
  assign pins[2] = {hs[2], vs[2], pr[2], pg[2], pb[2]};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int h_tot(input int d);
    return T_HV[d] + T_HF[d] + T_HS[d] + T_HB[d];
  endfunction

  function automatic int v_tot(input int d);
    return T_VV[d] + T_VF[d] + T_VS[d] + T_VB[d];
  endfunction

  function automatic logic [13:0] exp_pins(input int d, input int h, input int v);
    logic        act, hsn, vsn;
    logic [16:0] a;
    logic [11:0] rgb;
    act = (h < T_HV[d]) && (v < T_VV[d]);
    hsn = !((h >= T_HV[d] + T_HF[d]) && (h < T_HV[d] + T_HF[d] + T_HS[d]));
    vsn = !((v >= T_VV[d] + T_VF[d]) && (v < T_VV[d] + T_VF[d] + T_VS[d]));
    a   = 17'((v / 2) * T_FBW[d] + h / 2);
    rgb = !act ? 12'h000 : (force_fff ? 12'hFFF : a[11:0]);
    return {hsn, vsn, rgb};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      mh[d] = 0;
      mv[d] = 0;
      maddr[d] = '0;
      hs_run[d] = 0;
      first_fall[d] = -1;
    end
    vs_run = 0;
    last_fs = 0;
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 1 + T_LAT[0]; i++) q0.push_back(14'h3000);
    for (int i = 0; i < 1 + T_LAT[1]; i++) q1.push_back(14'h3000);
    for (int i = 0; i < 1 + T_LAT[2]; i++) q2.push_back(14'h3000);
  endtask

  task automatic reset_checks();
    for (int d = 0; d < ND; d++) begin
      check_val($sformatf("rst_pins%0d", d), 32'(pins[d]), 32'h3000);
      check_val($sformatf("rst_addr%0d", d), 32'(addr[d]), 32'h0);
      check_val($sformatf("rst_fs%0d", d), 32'(fs[d]), 32'h0);
      check_val($sformatf("rst_vb%0d", d), 32'(vb[d]), 32'h0);
    end
  endtask

  // Called at the negedge after posedge k; consumes the model state that edge used
  task automatic step_all(input int k);
    for (int d = 0; d < ND; d++) begin
      logic [13:0] e, e_now;
      logic        act, efs, evb;
      act = (mh[d] < T_HV[d]) && (mv[d] < T_VV[d]);
      e   = exp_pins(d, mh[d], mv[d]);
      if (act) maddr[d] = 17'((mv[d] / 2) * T_FBW[d] + mh[d] / 2);
      efs = (mh[d] == h_tot(d) - 1) && (mv[d] == v_tot(d) - 1);
      evb = (mv[d] >= T_VV[d]);
      e_now = 14'h0;
      case (d)
        0: begin q0.push_back(e); e_now = q0.pop_front(); end
        1: begin q1.push_back(e); e_now = q1.pop_front(); end
        default: begin q2.push_back(e); e_now = q2.pop_front(); end
      endcase
      check_val($sformatf("pins%0d@%0d", d, k), 32'(pins[d]), 32'(e_now));
      check_val($sformatf("addr%0d@%0d", d, k), 32'(addr[d]), 32'(maddr[d]));
      check_val($sformatf("fs%0d@%0d", d, k), 32'(fs[d]), 32'(efs));
      check_val($sformatf("vb%0d@%0d", d, k), 32'(vb[d]), 32'(evb));
      if (mh[d] == h_tot(d) - 1) begin
        mh[d] = 0;
        mv[d] = (mv[d] == v_tot(d) - 1) ? 0 : mv[d] + 1;
      end else begin
        mh[d] = mh[d] + 1;
      end
    end
  endtask

  task automatic measure(input int k);
    for (int d = 0; d < 2; d++) begin
      if (!hs[d]) begin
        if (hs_run[d] == 0 && first_fall[d] < 0) begin
          first_fall[d] = k;
          check_val($sformatf("hs_fall%0d", d), 32'(k), 32'(656 + 2 + T_LAT[d]));
        end
        hs_run[d]++;
      end else if (hs_run[d] > 0) begin
        check_val($sformatf("hs_width%0d", d), 32'(hs_run[d]), 32'(T_HS[d]));
        hs_run[d] = 0;
      end
      if (!force_fff && (k == 1602 + T_LAT[d] || k == 1603 + T_LAT[d]))
        check_val($sformatf("l2_px0_%0d@%0d", d, k), 32'(pins[d][11:0]), 32'h140);
      if (!force_fff && k == 1604 + T_LAT[d])
        check_val($sformatf("l2_px1_%0d", d), 32'(pins[d][11:0]), 32'h141);
    end
    if (!vs[2]) begin
      vs_run++;
    end else if (vs_run > 0) begin
      check_val("vs_width2", 32'(vs_run), 32'(T_VS[2] * h_tot(2)));
      vs_run = 0;
    end
    if (fs[2]) begin
      check_val("fs_period2", 32'(k - last_fs), 32'(h_tot(2) * v_tot(2)));
      last_fs = k;
    end
  endtask

  initial begin
    logic [9:0] th [4];
    logic [9:0] tv [4];
    int         ta [4];
    clk = 1'b0;
    rst_n = 1'b0;
    force_fff = 1'b0;
    n_tests = 0;
    n_fail = 0;
    model_reset();

    th = '{10'd1, 10'd2, 10'd0, 10'd639};
    tv = '{10'd1, 10'd0, 10'd2, 10'd479};
    ta = '{0, 1, 320, 76799};
    for (int i = 0; i < 4; i++)
      check_val($sformatf("fb_addr%0d", i), 32'(vga_pkg::fb_addr(th[i], tv[i], 320)), 32'(ta[i]));

    repeat (10) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    for (int k = 1; k <= 2600; k++) begin
      @(negedge clk);
      step_all(k);
      measure(k);
    end

    // Mid-line reset, then a run with saturated read data to expose any blanking leak
    rst_n = 1'b0;
    force_fff = 1'b1;
    repeat (10) @(negedge clk);
    reset_checks();
    model_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      step_all(k);
      measure(k);
    end

    for (int d = 0; d < 2; d++)
      check_val($sformatf("hs_seen%0d", d), 32'(first_fall[d] >= 0), 32'h1);
    check_val("fs_seen2", 32'(last_fs > 0), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
